// File: rtl/mc_ctrl_exc.sv
// mc_ctrl_exc: multi-cycle MIPS control FSM with precise traps, ERET and a memory-wait timeout.
module mc_ctrl_exc #(
    parameter int MIO_TIMEOUT = 15,
    parameter bit EN_OVF_TRAP = 1'b1,
    parameter bit IE_RESET    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Inst_in,
    input  logic        zero,
    input  logic        overflow,
    input  logic        MIO_ready,
    input  logic        irq,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        Beq,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        ALUSrcA,
    output logic        RegWrite,
    output logic        CPU_MIO,
    output logic [1:0]  MemtoReg,
    output logic [1:0]  RegDst,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSource,
    output logic        EPCSel,
    output logic [2:0]  ALU_operation,
    output logic        EPCWrite,
    output logic        CauseWrite,
    output logic [1:0]  Cause,
    output logic [4:0]  state_out
);
    typedef enum logic [4:0] {
        S_IF, S_ID, S_EX_R, S_EX_I, S_WB_R, S_WB_I, S_EX_MEM, S_MEM_RD, S_MEM_WR,
        S_WB_LW, S_BR, S_J, S_JAL, S_JR, S_JALR, S_LUI, S_TRAP, S_ERET
    } state_t;

    localparam int CW = (MIO_TIMEOUT > 1) ? $clog2(MIO_TIMEOUT + 1) : 1;

    state_t        r_state, w_next, w_nx, w_dec;
    logic [CW-1:0] r_cnt;
    logic          r_ie;
    logic [1:0]    r_cause, w_cause, w_ecause;
    logic [5:0]    w_op, w_fn;
    logic [4:0]    w_st;
    logic [2:0]    w_r_alu, w_i_alu, w_alu;
    logic          w_r_ok, w_i_ok, w_ovf_trap, w_tmo, w_wait, w_exc, w_chk, w_unused;

    assign w_op      = Inst_in[31:26];
    assign w_fn      = Inst_in[5:0];
    assign w_unused  = ^{zero, Inst_in[25:6]};
    assign state_out = r_state;

    always_comb begin
        w_r_alu = 3'b010;
        w_r_ok  = 1'b1;
        case (w_fn)
            6'b100000: w_r_alu = 3'b010;
            6'b100010: w_r_alu = 3'b110;
            6'b100100: w_r_alu = 3'b000;
            6'b100101: w_r_alu = 3'b001;
            6'b100111: w_r_alu = 3'b100;
            6'b101010: w_r_alu = 3'b111;
            6'b000010: w_r_alu = 3'b101;
            6'b000000: w_r_alu = 3'b011;
            default:   w_r_ok  = 1'b0;
        endcase
    end

    assign w_i_alu = (w_op == 6'b001010) ? 3'b111 :
                     (w_op == 6'b001100) ? 3'b000 :
                     (w_op == 6'b001101) ? 3'b001 :
                     (w_op == 6'b001110) ? 3'b011 : 3'b010;
    assign w_i_ok  = w_op inside {6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110};
    assign w_alu   = (w_op == 6'b000000) ? w_r_alu : w_i_alu;

    assign w_ovf_trap = EN_OVF_TRAP && overflow &&
                        ((w_op == 6'b000000 && (w_fn == 6'b100000 || w_fn == 6'b100010)) ||
                         w_op == 6'b001000);

    assign w_dec = (w_op == 6'b000000) ? ((w_fn == 6'b001000) ? S_JR :
                                          (w_fn == 6'b001001) ? S_JALR :
                                          w_r_ok ? S_EX_R : S_TRAP) :
                   (w_op == 6'b100011 || w_op == 6'b101011) ? S_EX_MEM :
                   w_i_ok ? S_EX_I :
                   (w_op == 6'b000100 || w_op == 6'b000101) ? S_BR :
                   (w_op == 6'b000010) ? S_J :
                   (w_op == 6'b000011) ? S_JAL :
                   (w_op == 6'b001111) ? S_LUI :
                   (w_op == 6'b010000 && w_fn == 6'b011000) ? S_ERET : S_TRAP;

    assign w_wait = r_state inside {S_IF, S_MEM_RD, S_MEM_WR};
    assign w_tmo  = (MIO_TIMEOUT != 0) && !MIO_ready && (int'(r_cnt) == MIO_TIMEOUT - 1);

    // Reset is decoded as an illegal encoding so every enable stays low while it is held.
    assign w_st = reset ? 5'h1f : r_state;

    always_comb begin
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        Beq           = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        ALUSrcA       = 1'b0;
        RegWrite      = 1'b0;
        CPU_MIO       = 1'b0;
        MemtoReg      = 2'b00;
        RegDst        = 2'b00;
        ALUSrcB       = 2'b00;
        PCSource      = 2'b00;
        EPCSel        = 1'b0;
        ALU_operation = 3'b000;
        EPCWrite      = 1'b0;
        CauseWrite    = 1'b0;
        Cause         = 2'b00;
        w_nx          = S_IF;
        w_exc         = 1'b0;
        w_ecause      = 2'd0;
        w_chk         = 1'b1;
        case (w_st)
            S_IF: begin
                MemRead       = 1'b1;
                CPU_MIO       = 1'b1;
                ALUSrcB       = 2'b01;
                ALU_operation = 3'b010;
                PCWrite       = MIO_ready;
                IRWrite       = MIO_ready;
                w_nx          = MIO_ready ? S_ID : S_IF;
                w_exc         = w_tmo;
                w_ecause      = 2'd3;
            end
            S_ID: begin
                ALUSrcB       = 2'b11;
                ALU_operation = 3'b010;
                w_nx          = w_dec;
                w_exc         = (w_dec == S_TRAP);
                w_ecause      = 2'd1;
            end
            S_EX_R: begin
                ALUSrcA       = 1'b1;
                ALU_operation = w_alu;
                w_nx          = S_WB_R;
            end
            S_EX_I: begin
                ALUSrcA       = 1'b1;
                ALUSrcB       = 2'b10;
                ALU_operation = w_alu;
                w_nx          = S_WB_I;
            end
            S_WB_R: begin
                ALUSrcA       = 1'b1;
                ALU_operation = w_alu;
                RegWrite      = !w_ovf_trap;
                RegDst        = 2'b01;
                w_exc         = w_ovf_trap;
                w_ecause      = 2'd2;
            end
            S_WB_I: begin
                ALUSrcA       = 1'b1;
                ALUSrcB       = 2'b10;
                ALU_operation = w_alu;
                RegWrite      = !w_ovf_trap;
                w_exc         = w_ovf_trap;
                w_ecause      = 2'd2;
            end
            S_EX_MEM: begin
                ALUSrcA       = 1'b1;
                ALUSrcB       = 2'b10;
                ALU_operation = 3'b010;
                w_nx          = (w_op == 6'b100011) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                IorD     = 1'b1;
                CPU_MIO  = 1'b1;
                MemRead  = 1'b1;
                w_nx     = MIO_ready ? S_WB_LW : S_MEM_RD;
                w_exc    = w_tmo;
                w_ecause = 2'd3;
            end
            S_MEM_WR: begin
                IorD     = 1'b1;
                CPU_MIO  = 1'b1;
                MemWrite = 1'b1;
                w_nx     = MIO_ready ? S_IF : S_MEM_WR;
                w_exc    = w_tmo;
                w_ecause = 2'd3;
            end
            S_WB_LW: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b01;
            end
            S_BR: begin
                ALUSrcA       = 1'b1;
                ALU_operation = 3'b110;
                PCWriteCond   = 1'b1;
                PCSource      = 2'b01;
                Beq           = (w_op == 6'b000100);
            end
            S_J: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_JAL: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                RegWrite = 1'b1;
                RegDst   = 2'b10;
                MemtoReg = 2'b11;
            end
            S_JR: begin
                PCWrite       = 1'b1;
                ALUSrcA       = 1'b1;
                ALU_operation = 3'b010;
            end
            S_JALR: begin
                PCWrite       = 1'b1;
                ALUSrcA       = 1'b1;
                ALU_operation = 3'b010;
                RegWrite      = 1'b1;
                RegDst        = 2'b01;
                MemtoReg      = 2'b11;
            end
            S_LUI: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b10;
            end
            S_TRAP: begin
                EPCWrite   = 1'b1;
                CauseWrite = 1'b1;
                PCWrite    = 1'b1;
                PCSource   = 2'b11;
                Cause      = r_cause;
                w_chk      = 1'b0;
            end
            S_ERET: begin
                PCWrite  = 1'b1;
                PCSource = 2'b11;
                EPCSel   = 1'b1;
                w_chk    = 1'b0;
            end
            default: w_chk = 1'b0;
        endcase
        // Synchronous exceptions outrank the interrupt, which only lands on an instruction boundary.
        w_next  = (w_exc || (w_chk && w_nx == S_IF && irq && r_ie)) ? S_TRAP : w_nx;
        w_cause = w_exc ? w_ecause : 2'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IF;
            r_cnt   <= '0;
            r_ie    <= IE_RESET;
            r_cause <= 2'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next == r_state && w_wait && !MIO_ready) ? r_cnt + 1'b1 : '0;
            r_ie    <= (r_state == S_TRAP) ? 1'b0 : (r_state == S_ERET) ? 1'b1 : r_ie;
            if (w_next == S_TRAP)
                r_cause <= w_cause;
        end
    end
endmodule

// File: tb/tb_mc_ctrl_exc.sv
// tb_mc_ctrl_exc: random instruction stream against a phase-sequence reference model with a scoreboard.
module tb_mc_ctrl_exc;
    localparam int TMO    = 15;
    localparam bit OVF_EN = 1'b1;
    localparam bit IE_RST = 1'b1;

    typedef enum int {P_IF, P_ID, P_EXR, P_EXI, P_WBR, P_WBI, P_EXM, P_MRD, P_MWR, P_WLW,
                      P_BR, P_J, P_JAL, P_JR, P_JALR, P_LUI, P_ERET, P_TRAP} ph_e;
    typedef enum int {K_R, K_I, K_LW, K_SW, K_BR, K_J, K_JAL, K_JR, K_JALR, K_LUI, K_ERET, K_ILL} kind_e;

    typedef struct packed {
        logic pcw, pcwc, beq, iord, mrd, mwr, irw, asa, rw, mio;
        logic [1:0] m2r, rdst, asb, pcs;
        logic epcs;
        logic [2:0] alu;
        logic epcw, cw;
        logic [1:0] cause;
    } ctl_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       fx;
        logic [2:0] alu;
        kind_e      k;
        logic       ov;
    } ins_t;

    typedef struct {
        ctl_t c;
        ph_e  p;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Inst_in = 32'h0;
    logic        zero = 1'b0, overflow = 1'b0, MIO_ready = 1'b0, irq = 1'b0;
    logic        PCWrite, PCWriteCond, Beq, IorD, MemRead, MemWrite, IRWrite, ALUSrcA, RegWrite, CPU_MIO;
    logic [1:0]  MemtoReg, RegDst, ALUSrcB, PCSource, Cause;
    logic        EPCSel, EPCWrite, CauseWrite;
    logic [2:0]  ALU_operation;
    logic [4:0]  state_out;

    ins_t tbl[27];
    exp_t q[$];
    int   checks = 0, failures = 0;

    always #5 clk = ~clk;

    mc_ctrl_exc #(.MIO_TIMEOUT(TMO), .EN_OVF_TRAP(OVF_EN), .IE_RESET(IE_RST)) u_dut (
        .clk(clk), .reset(reset), .Inst_in(Inst_in), .zero(zero), .overflow(overflow),
        .MIO_ready(MIO_ready), .irq(irq), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Beq(Beq),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
        .RegWrite(RegWrite), .CPU_MIO(CPU_MIO), .MemtoReg(MemtoReg), .RegDst(RegDst), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .EPCSel(EPCSel), .ALU_operation(ALU_operation), .EPCWrite(EPCWrite),
        .CauseWrite(CauseWrite), .Cause(Cause), .state_out(state_out)
    );

    function automatic ins_t mk(logic [5:0] op, logic [5:0] fn, logic fx, logic [2:0] alu, kind_e k, logic ov);
        ins_t e;
        e.op = op; e.fn = fn; e.fx = fx; e.alu = alu; e.k = k; e.ov = ov;
        return e;
    endfunction

    // Phase list each instruction class walks through after fetch.
    function automatic ph_e seq_of(kind_e k, int i);
        ph_e s[5];
        s = '{default: P_IF};
        case (k)
            K_R:    s = '{P_ID, P_EXR, P_WBR, P_IF, P_IF};
            K_I:    s = '{P_ID, P_EXI, P_WBI, P_IF, P_IF};
            K_LW:   s = '{P_ID, P_EXM, P_MRD, P_WLW, P_IF};
            K_SW:   s = '{P_ID, P_EXM, P_MWR, P_IF, P_IF};
            K_BR:   s = '{P_ID, P_BR, P_IF, P_IF, P_IF};
            K_J:    s = '{P_ID, P_J, P_IF, P_IF, P_IF};
            K_JAL:  s = '{P_ID, P_JAL, P_IF, P_IF, P_IF};
            K_JR:   s = '{P_ID, P_JR, P_IF, P_IF, P_IF};
            K_JALR: s = '{P_ID, P_JALR, P_IF, P_IF, P_IF};
            K_LUI:  s = '{P_ID, P_LUI, P_IF, P_IF, P_IF};
            K_ERET: s = '{P_ID, P_ERET, P_IF, P_IF, P_IF};
            default: s = '{P_ID, P_IF, P_IF, P_IF, P_IF};
        endcase
        return s[i];
    endfunction

    function automatic ctl_t exp_ctl(ph_e p, ins_t e, logic rdy, logic ovt, logic [1:0] cs);
        ctl_t c;
        c = '0;
        case (p)
            P_IF:   begin c.mrd = 1; c.mio = 1; c.asb = 2'b01; c.alu = 3'b010; c.irw = rdy; c.pcw = rdy; end
            P_ID:   begin c.asb = 2'b11; c.alu = 3'b010; end
            P_EXR:  begin c.asa = 1; c.alu = e.alu; end
            P_EXI:  begin c.asa = 1; c.asb = 2'b10; c.alu = e.alu; end
            P_WBR:  begin c.asa = 1; c.alu = e.alu; c.rw = !ovt; c.rdst = 2'b01; end
            P_WBI:  begin c.asa = 1; c.asb = 2'b10; c.alu = e.alu; c.rw = !ovt; end
            P_EXM:  begin c.asa = 1; c.asb = 2'b10; c.alu = 3'b010; end
            P_MRD:  begin c.iord = 1; c.mio = 1; c.mrd = 1; end
            P_MWR:  begin c.iord = 1; c.mio = 1; c.mwr = 1; end
            P_WLW:  begin c.rw = 1; c.m2r = 2'b01; end
            P_BR:   begin c.asa = 1; c.alu = 3'b110; c.pcwc = 1; c.pcs = 2'b01; c.beq = (e.op == 6'b000100); end
            P_J:    begin c.pcw = 1; c.pcs = 2'b10; end
            P_JAL:  begin c.pcw = 1; c.pcs = 2'b10; c.rw = 1; c.rdst = 2'b10; c.m2r = 2'b11; end
            P_JR:   begin c.pcw = 1; c.asa = 1; c.alu = 3'b010; end
            P_JALR: begin c.pcw = 1; c.asa = 1; c.alu = 3'b010; c.rw = 1; c.rdst = 2'b01; c.m2r = 2'b11; end
            P_LUI:  begin c.rw = 1; c.m2r = 2'b10; end
            P_TRAP: begin c.epcw = 1; c.cw = 1; c.pcw = 1; c.pcs = 2'b11; c.cause = cs; end
            P_ERET: begin c.pcw = 1; c.pcs = 2'b11; c.epcs = 1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    always @(negedge clk) begin
        exp_t x;
        ctl_t g;
        if (q.size() != 0) begin
            x = q.pop_front();
            g = {PCWrite, PCWriteCond, Beq, IorD, MemRead, MemWrite, IRWrite, ALUSrcA, RegWrite, CPU_MIO,
                 MemtoReg, RegDst, ALUSrcB, PCSource, EPCSel, ALU_operation, EPCWrite, CauseWrite, Cause};
            checks++;
            if (g !== x.c) begin
                failures++;
                $display("FAIL ctl phase=%s got=%h exp=%h", x.p.name(), g, x.c);
            end
        end
    end

    initial begin
        ins_t       m_e;
        ph_e        m_ph, nph;
        exp_t       t;
        logic [31:0] m_inst;
        logic [1:0] m_cause, cs;
        int         m_i, m_w;
        bit         m_ie, m_dead, rst, rdy, ovt, stall, exc;
        tbl[0]  = mk(6'h00, 6'b100000, 1, 3'b010, K_R, 1);
        tbl[1]  = mk(6'h00, 6'b100010, 1, 3'b110, K_R, 1);
        tbl[2]  = mk(6'h00, 6'b100100, 1, 3'b000, K_R, 0);
        tbl[3]  = mk(6'h00, 6'b100101, 1, 3'b001, K_R, 0);
        tbl[4]  = mk(6'h00, 6'b100111, 1, 3'b100, K_R, 0);
        tbl[5]  = mk(6'h00, 6'b101010, 1, 3'b111, K_R, 0);
        tbl[6]  = mk(6'h00, 6'b000010, 1, 3'b101, K_R, 0);
        tbl[7]  = mk(6'h00, 6'b000000, 1, 3'b011, K_R, 0);
        tbl[8]  = mk(6'h00, 6'b001000, 1, 3'b010, K_JR, 0);
        tbl[9]  = mk(6'h00, 6'b001001, 1, 3'b010, K_JALR, 0);
        tbl[10] = mk(6'b001000, 6'h0, 0, 3'b010, K_I, 1);
        tbl[11] = mk(6'b001010, 6'h0, 0, 3'b111, K_I, 0);
        tbl[12] = mk(6'b001100, 6'h0, 0, 3'b000, K_I, 0);
        tbl[13] = mk(6'b001101, 6'h0, 0, 3'b001, K_I, 0);
        tbl[14] = mk(6'b001110, 6'h0, 0, 3'b011, K_I, 0);
        tbl[15] = mk(6'b100011, 6'h0, 0, 3'b010, K_LW, 0);
        tbl[16] = mk(6'b101011, 6'h0, 0, 3'b010, K_SW, 0);
        tbl[17] = mk(6'b000100, 6'h0, 0, 3'b110, K_BR, 0);
        tbl[18] = mk(6'b000101, 6'h0, 0, 3'b110, K_BR, 0);
        tbl[19] = mk(6'b000010, 6'h0, 0, 3'b000, K_J, 0);
        tbl[20] = mk(6'b000011, 6'h0, 0, 3'b000, K_JAL, 0);
        tbl[21] = mk(6'b001111, 6'h0, 0, 3'b000, K_LUI, 0);
        tbl[22] = mk(6'b010000, 6'b011000, 1, 3'b000, K_ERET, 0);
        tbl[23] = mk(6'b010000, 6'b011000, 1, 3'b000, K_ERET, 0);
        tbl[24] = mk(6'b111111, 6'h0, 0, 3'b000, K_ILL, 0);
        tbl[25] = mk(6'h00, 6'b111111, 1, 3'b000, K_ILL, 0);
        tbl[26] = mk(6'b010000, 6'b000000, 1, 3'b000, K_ILL, 0);
        m_e = tbl[0]; m_inst = 32'h0; m_ph = P_IF; m_i = 0; m_w = 0;
        m_ie = IE_RST; m_dead = 0; m_cause = 2'd0;
        for (int n = 0; n < 4000; n++) begin
            @(posedge clk);
            #1;
            rst       = (n < 3) || ($urandom_range(0, 149) == 0);
            rdy       = !m_dead && ($urandom_range(0, 9) < 7);
            reset     = rst;
            overflow  = ($urandom_range(0, 3) == 0);
            irq       = ($urandom_range(0, 7) == 0);
            zero      = 1'($urandom_range(0, 1));
            MIO_ready = rdy;
            Inst_in   = m_inst;
            if (rst) begin
                t.c = '0; t.p = P_IF;
                q.push_back(t);
                m_ph = P_IF; m_w = 0; m_ie = IE_RST; m_dead = 0;
            end else begin
                ovt = OVF_EN && overflow && m_e.ov && (m_ph == P_WBR || m_ph == P_WBI);
                t.c = exp_ctl(m_ph, m_e, rdy, ovt, m_cause); t.p = m_ph;
                q.push_back(t);
                stall = (m_ph == P_IF || m_ph == P_MRD || m_ph == P_MWR) && !rdy;
                exc = 0; cs = 2'd0; nph = P_IF;
                if (stall) begin
                    nph = m_ph;
                    if (TMO != 0 && m_w + 1 == TMO) begin exc = 1; cs = 2'd3; end
                end else if (m_ph == P_IF) begin
                    m_e    = tbl[$urandom_range(0, 26)];
                    m_inst = {m_e.op, 20'($urandom), m_e.fx ? m_e.fn : 6'($urandom)};
                    m_i    = 0;
                    nph    = seq_of(m_e.k, 0);
                end else if (m_ph == P_TRAP || m_ph == P_ERET) begin
                    m_ie = (m_ph == P_ERET);
                end else begin
                    if (m_ph == P_ID && m_e.k == K_ILL) begin exc = 1; cs = 2'd1; end
                    if (ovt) begin exc = 1; cs = 2'd2; end
                    m_i++;
                    nph = seq_of(m_e.k, m_i);
                end
                if (exc || (nph == P_IF && m_ph != P_TRAP && m_ph != P_ERET && irq && m_ie)) begin
                    m_cause = cs;
                    nph = P_TRAP;
                end
                m_w = (stall && nph == m_ph) ? m_w + 1 : 0;
                if (nph != m_ph)
                    m_dead = (nph == P_IF || nph == P_MRD || nph == P_MWR) && ($urandom_range(0, 5) == 0);
                m_ph = nph;
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
